sr_hazard_unit: RTL and testbench

Parametrised hazard-control unit for the pipelined schoolRISCV core. It sits between the register file, the in-flight pipeline stages and the fetch stage. It resolves read-after-write hazards on the two decode source operands, either by priority forwarding from N producer stages or by stalling. It also runs the branch-freeze state machine that holds fetch for a configurable penalty and then redirects the PC.

---
 rtl/sr_hazard_unit.sv | 139 +++++++++++++
 tb/tb_sr_hazard_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sr_hazard_unit.sv
// rtl/sr_hazard_unit.sv - RAW hazard resolution (forward or stall) and branch-freeze PC control
// Build option: define SR_HAZARD_FWD_EN to forward producer results instead of stalling.
module sr_hazard_unit #(
  parameter int              XLEN           = 32,
  parameter int              REG_ADDR_W     = 5,
  parameter int              FWD_STAGES     = 2,
  parameter int              BRANCH_PENALTY = 3,
  parameter logic [XLEN-1:0] RESET_PC       = '0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [REG_ADDR_W-1:0]            rs1_i,
  input  logic [REG_ADDR_W-1:0]            rs2_i,
  input  logic [XLEN-1:0]                  rd1_i,
  input  logic [XLEN-1:0]                  rd2_i,
  input  logic [FWD_STAGES-1:0]            fwdWe_i,
  input  logic [FWD_STAGES*REG_ADDR_W-1:0] fwdRd_i,
  input  logic [FWD_STAGES*XLEN-1:0]       fwdData_i,
  input  logic                             branch_i,
  input  logic [XLEN-1:0]                  pcPlus4_i,
  input  logic [XLEN-1:0]                  pcBranch_i,
  output logic [XLEN-1:0]                  srcA_o,
  output logic [XLEN-1:0]                  srcB_o,
  output logic                             stall_o,
  output logic                             freeze_o,
  output logic [XLEN-1:0]                  pcTarget_o,
  output logic                             redirect_o
);

  localparam int CNT_W = $clog2(BRANCH_PENALTY + 1);

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    FLUSH    = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  state_t            state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic              freeze_q, freeze_n;
  logic              redirect_q, redirect_n;
  logic [XLEN-1:0]   pc_q, pc_n;

  logic [FWD_STAGES-1:0] hit1, hit2;

  // x0 is hard-wired zero, so a producer targeting it never creates a hazard
  always_comb begin
    hit1 = '0;
    hit2 = '0;
    for (int k = 0; k < FWD_STAGES; k++) begin
      hit1[k] = fwdWe_i[k] && (fwdRd_i[k*REG_ADDR_W +: REG_ADDR_W] == rs1_i) && (rs1_i != '0);
      hit2[k] = fwdWe_i[k] && (fwdRd_i[k*REG_ADDR_W +: REG_ADDR_W] == rs2_i) && (rs2_i != '0);
    end
  end

`ifdef SR_HAZARD_FWD_EN
  // Walk oldest to youngest so the lowest-index hit overrides the rest
  always_comb begin
    srcA_o = rd1_i;
    srcB_o = rd2_i;
    for (int k = FWD_STAGES - 1; k >= 0; k--) begin
      if (hit1[k]) srcA_o = fwdData_i[k*XLEN +: XLEN];
      if (hit2[k]) srcB_o = fwdData_i[k*XLEN +: XLEN];
    end
  end

  assign stall_o = 1'b0;
`else
  logic unused_fwd_data;
  assign unused_fwd_data = ^fwdData_i;

  assign srcA_o  = rd1_i;
  assign srcB_o  = rd2_i;
  assign stall_o = (state_q == RUN) && ((|hit1) || (|hit2));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      cnt_q      <= '0;
      freeze_q   <= 1'b0;
      redirect_q <= 1'b0;
      pc_q       <= RESET_PC;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      freeze_q   <= freeze_n;
      redirect_q <= redirect_n;
      pc_q       <= pc_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    freeze_n   = freeze_q;
    redirect_n = redirect_q;
    pc_n       = pc_q;
    case (state_q)
      BOOT: begin
        state_n = RUN;
      end
      RUN: begin
        if (stall_o) begin
          pc_n = pc_q;
        end else if (branch_i) begin
          state_n  = FLUSH;
          freeze_n = 1'b1;
          cnt_n    = CNT_W'(BRANCH_PENALTY - 1);
        end else begin
          pc_n = pcPlus4_i;
        end
      end
      FLUSH: begin
        if (cnt_q != '0) begin
          cnt_n = cnt_q - 1'b1;
        end else begin
          state_n    = REDIRECT;
          pc_n       = pcBranch_i;
          redirect_n = 1'b1;
        end
      end
      REDIRECT: begin
        freeze_n   = 1'b0;
        redirect_n = 1'b0;
        state_n    = RUN;
      end
      default: begin
        state_n = BOOT;
      end
    endcase
  end

  assign freeze_o   = freeze_q;
  assign redirect_o = redirect_q;
  assign pcTarget_o = pc_q;

endmodule

// File: tb/tb_sr_hazard_unit.sv
// tb/tb_sr_hazard_unit.sv - directed-vector bench for sr_hazard_unit
module tb_sr_hazard_unit;

  localparam int XLEN = 32;
  localparam int RAW  = 5;
  localparam int NS   = 2;
  localparam logic [31:0] RPC = 32'h80;
`ifdef SR_HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [RAW-1:0]  rs1_i, rs2_i;
  logic [XLEN-1:0] rd1_i, rd2_i;
  logic [NS-1:0]   fwdWe_i;
  logic [NS*RAW-1:0]  fwdRd_i;
  logic [NS*XLEN-1:0] fwdData_i;
  logic            branch_i;
  logic [XLEN-1:0] pcPlus4_i, pcBranch_i;
  logic [XLEN-1:0] srcA_o, srcB_o, pcTarget_o;
  logic            stall_o, freeze_o, redirect_o;

  int vec_cnt = 0;
  int err_cnt = 0;

  sr_hazard_unit #(
    .XLEN(XLEN), .REG_ADDR_W(RAW), .FWD_STAGES(NS),
    .BRANCH_PENALTY(3), .RESET_PC(RPC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd1_i(rd1_i), .rd2_i(rd2_i),
    .fwdWe_i(fwdWe_i), .fwdRd_i(fwdRd_i), .fwdData_i(fwdData_i),
    .branch_i(branch_i), .pcPlus4_i(pcPlus4_i), .pcBranch_i(pcBranch_i),
    .srcA_o(srcA_o), .srcB_o(srcB_o), .stall_o(stall_o),
    .freeze_o(freeze_o), .pcTarget_o(pcTarget_o), .redirect_o(redirect_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int k, input logic we, input logic [RAW-1:0] rd, input logic [XLEN-1:0] data);
    fwdWe_i[k]              = we;
    fwdRd_i[k*RAW +: RAW]   = rd;
    fwdData_i[k*XLEN +: XLEN] = data;
  endtask

  initial begin
    rst_n = 1'b0;
    rs1_i = '0; rs2_i = '0; rd1_i = '0; rd2_i = '0;
    fwdWe_i = '0; fwdRd_i = '0; fwdData_i = '0;
    branch_i = 1'b0; pcPlus4_i = 32'h100; pcBranch_i = 32'h40;

    #12;
    check("rst_freeze", {31'd0, freeze_o}, 32'd0);
    check("rst_redirect", {31'd0, redirect_o}, 32'd0);
    check("rst_pc", pcTarget_o, RPC);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    tick();
    check("boot_pc", pcTarget_o, RPC);
    tick();
    check("run_pc", pcTarget_o, 32'h100);

    // operand selection (no edges while hazards are present)
    rs1_i = 5'd5; rd1_i = 32'h33;
    set_slot(0, 1'b1, 5'd5, 32'h11);
    set_slot(1, 1'b1, 5'd5, 32'h22);
    #1;
    check("fwd_both_srcA", srcA_o, FWD ? 32'h11 : 32'h33);
    check("fwd_both_stall", {31'd0, stall_o}, FWD ? 32'd0 : 32'd1);
    fwdWe_i[0] = 1'b0; #1;
    check("fwd_slot1_srcA", srcA_o, FWD ? 32'h22 : 32'h33);
    check("fwd_slot1_stall", {31'd0, stall_o}, FWD ? 32'd0 : 32'd1);
    fwdWe_i[1] = 1'b0; #1;
    check("fwd_none_srcA", srcA_o, 32'h33);
    check("fwd_none_stall", {31'd0, stall_o}, 32'd0);
    rs1_i = '0; rs2_i = '0; rd2_i = '0;
    set_slot(0, 1'b1, 5'd0, 32'hFF); #1;
    check("x0_srcB", srcB_o, 32'h0);
    check("x0_stall", {31'd0, stall_o}, 32'd0);
    set_slot(0, 1'b0, 5'd0, 32'h0);

    // two-cycle hazard on rs1
    pcPlus4_i = 32'h104; rs1_i = 5'd7; rd1_i = 32'h77;
    set_slot(1, 1'b1, 5'd7, 32'h99); #1;
    check("haz_stall0", {31'd0, stall_o}, FWD ? 32'd0 : 32'd1);
    check("haz_srcA0", srcA_o, FWD ? 32'h99 : 32'h77);
    tick();
    check("haz_pc1", pcTarget_o, FWD ? 32'h104 : 32'h100);
    check("haz_stall1", {31'd0, stall_o}, FWD ? 32'd0 : 32'd1);
    tick();
    check("haz_pc2", pcTarget_o, FWD ? 32'h104 : 32'h100);
    fwdWe_i[1] = 1'b0; #1;
    check("haz_clear_stall", {31'd0, stall_o}, 32'd0);
    tick();
    check("haz_pc3", pcTarget_o, 32'h104);

    // branch with penalty 3, branch_i held into FLUSH, hazard presented during FLUSH
    pcBranch_i = 32'h40; pcPlus4_i = 32'h108; rs1_i = '0; branch_i = 1'b1;
    tick();
    check("br_T_freeze", {31'd0, freeze_o}, 32'd1);
    check("br_T_pc", pcTarget_o, 32'h104);
    rs1_i = 5'd7; set_slot(1, 1'b1, 5'd7, 32'h99); #1;
    check("br_flush_stall", {31'd0, stall_o}, 32'd0);
    tick();
    check("br_T1_freeze", {31'd0, freeze_o}, 32'd1);
    check("br_T1_redirect", {31'd0, redirect_o}, 32'd0);
    branch_i = 1'b0;
    tick();
    check("br_T2_pc", pcTarget_o, 32'h104);
    fwdWe_i[1] = 1'b0;
    tick();
    check("br_T3_pc", pcTarget_o, 32'h40);
    check("br_T3_redirect", {31'd0, redirect_o}, 32'd1);
    check("br_T3_freeze", {31'd0, freeze_o}, 32'd1);
    tick();
    check("br_T4_freeze", {31'd0, freeze_o}, 32'd0);
    check("br_T4_redirect", {31'd0, redirect_o}, 32'd0);
    check("br_T4_pc", pcTarget_o, 32'h40);
    tick();
    check("br_T5_pc", pcTarget_o, 32'h108);

    // branch coinciding with a one-cycle stall
    pcPlus4_i = 32'h10C; pcBranch_i = 32'h60; rs1_i = 5'd7;
    set_slot(1, 1'b1, 5'd7, 32'h99); branch_i = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      int acc;
      acc = FWD ? 1 : 2;
      tick();
      if (e == 1) fwdWe_i[1] = 1'b0;
      if (e == 2) branch_i = 1'b0;
      check($sformatf("bs_e%0d_freeze", e), {31'd0, freeze_o},
            (e >= acc && e <= acc + 3) ? 32'd1 : 32'd0);
      check($sformatf("bs_e%0d_redirect", e), {31'd0, redirect_o},
            (e == acc + 3) ? 32'd1 : 32'd0);
      check($sformatf("bs_e%0d_pc", e), pcTarget_o,
            (e >= acc + 5) ? 32'h10C : ((e >= acc + 3) ? 32'h60 : 32'h108));
    end

    // asynchronous reset in the middle of FLUSH
    rs1_i = '0; branch_i = 1'b1;
    tick();
    branch_i = 1'b0;
    tick();
    check("mid_flush_freeze", {31'd0, freeze_o}, 32'd1);
    #1 rst_n = 1'b0; pcPlus4_i = 32'h200;
    #1;
    check("async_rst_freeze", {31'd0, freeze_o}, 32'd0);
    check("async_rst_pc", pcTarget_o, RPC);
    check("async_rst_redirect", {31'd0, redirect_o}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
    check("rel_boot_pc", pcTarget_o, RPC);
    check("rel_boot_freeze", {31'd0, freeze_o}, 32'd0);
    tick();
    check("rel_run_pc", pcTarget_o, 32'h200);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
